// File: rtl/result_collector_if.sv
// ---------------------------------------------------------------------------
// result_collector_if
// Bundles the two data paths of the result collector:
//   - result stream from the PE array: res_valid / res_data / res_ready
//   - write port to the output memory: mem_req / mem_gnt / mem_addr / mem_wdata
// Modports:
//   slave  : the collector side (consumes results, issues memory writes)
//   master : the environment side (PE array + output memory)
// ---------------------------------------------------------------------------
interface result_collector_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 9
) ();

    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_ready;
    logic              mem_req;
    logic              mem_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport slave (
        input  res_valid,
        input  res_data,
        input  mem_gnt,
        output res_ready,
        output mem_req,
        output mem_addr,
        output mem_wdata
    );

    modport master (
        output res_valid,
        output res_data,
        output mem_gnt,
        input  res_ready,
        input  mem_req,
        input  mem_addr,
        input  mem_wdata
    );

endinterface

// File: rtl/result_collector.sv
// ---------------------------------------------------------------------------
// result_collector
// Collects NUM_RESULTS result words per run from the PE array, buffers them in
// a small FIFO and writes them to consecutive output-memory addresses starting
// at 0. When every result has been written it raises a 4-phase done request.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start_pulse     one-cycle run start (ignored unless idle)
//   bus (slave)     result stream in, memory write port out
//   done_req/ack    4-phase "results ready" handshake with system control
//   busy            high whenever the controller is not idle
//   overflow_err    sticky: a result was offered after the run was complete
// ---------------------------------------------------------------------------
module result_collector #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 9,
    parameter int NUM_RESULTS = 441,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_pulse,
    result_collector_if.slave   bus,
    output logic                done_req,
    input  logic                done_ack,
    output logic                busy,
    output logic                overflow_err
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] NUM_CNT  = CNT_W'(NUM_RESULTS);
    localparam logic [CNT_W-1:0] NUM_LAST = CNT_W'(NUM_RESULTS - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_NOTIFY  = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   acc_cnt_r;
    logic [CNT_W-1:0]   wr_cnt_r;
    logic [DATA_W-1:0]  fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [OCC_W-1:0]   occ_r;
    logic               done_req_r;
    logic               busy_r;
    logic               overflow_r;

    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               res_ready_s;
    logic               mem_req_s;
    logic               push_s;
    logic               pop_s;
    logic               start_s;
    logic               late_offer_s;

    assign fifo_full_s  = (occ_r == OCC_FULL);
    assign fifo_empty_s = (occ_r == {OCC_W{1'b0}});
    assign res_ready_s  = (state_r == ST_RUN) && !fifo_full_s;
    assign mem_req_s    = ((state_r == ST_RUN) || (state_r == ST_DRAIN)) && !fifo_empty_s;
    assign push_s       = bus.res_valid && res_ready_s;
    assign pop_s        = mem_req_s && bus.mem_gnt;
    assign start_s      = start_pulse && (state_r == ST_IDLE);
    assign late_offer_s = bus.res_valid && ((state_r == ST_DRAIN) ||
                                            (state_r == ST_NOTIFY) ||
                                            (state_r == ST_RELEASE));

    assign bus.res_ready = res_ready_s;
    assign bus.mem_req   = mem_req_s;
    assign bus.mem_addr  = wr_cnt_r[ADDR_W-1:0];
    // Stale FIFO contents are masked so the write data reads zero when idle.
    assign bus.mem_wdata = mem_req_s ? fifo_mem_r[rd_ptr_r] : {DATA_W{1'b0}};
    assign done_req      = done_req_r;
    assign busy          = busy_r;
    assign overflow_err  = overflow_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_pulse) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (push_s && (acc_cnt_r == NUM_LAST)) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if ((wr_cnt_r == NUM_CNT) && fifo_empty_s) begin
                    state_nxt_s = ST_NOTIFY;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_NOTIFY: begin
                if (done_ack) begin
                    state_nxt_s = ST_RELEASE;
                end else begin
                    state_nxt_s = ST_NOTIFY;
                end
            end
            ST_RELEASE: begin
                if (!done_ack) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RELEASE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Result FIFO: storage, pointers and occupancy; a run start empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            occ_r    <= {OCC_W{1'b0}};
        end else if (start_s) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            occ_r    <= {OCC_W{1'b0}};
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= bus.res_data;
                wr_ptr_r <= (wr_ptr_r == PTR_LAST) ? {PTR_W{1'b0}} : (wr_ptr_r + PTR_ONE);
            end
            if (pop_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? {PTR_W{1'b0}} : (rd_ptr_r + PTR_ONE);
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            if (push_s && !pop_s) begin
                occ_r <= occ_r + OCC_ONE;
            end else if (pop_s && !push_s) begin
                occ_r <= occ_r - OCC_ONE;
            end
        end
    end

    // Accept and write counters; wr_cnt doubles as the memory address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt_r <= {CNT_W{1'b0}};
            wr_cnt_r  <= {CNT_W{1'b0}};
        end else if (start_s) begin
            acc_cnt_r <= {CNT_W{1'b0}};
            wr_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                acc_cnt_r <= acc_cnt_r + CNT_ONE;
            end
            if (pop_s) begin
                wr_cnt_r <= wr_cnt_r + CNT_ONE;
            end
        end
    end

    // Registered status outputs derived from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_req_r <= 1'b0;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            done_req_r <= (state_nxt_s == ST_NOTIFY);
            busy_r     <= (state_nxt_s != ST_IDLE);
            if (start_s) begin
                overflow_r <= 1'b0;
            end else if (late_offer_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

endmodule
